bus_sel_encoder: RTL and testbench

- Sequential arbitrating encoder for the common-bus source select S2..S0: the reverse direction of the 3-to-8 decoder that fans S out to register output enables.
- Collects per-source bus requests, grants one source round-robin, and outputs a registered 3-bit select plus the matching one-hot grant.
- Code 0 means "no source driving the bus".
- Holds the grant until the owner releases or drops its request; counts contention cycles for debug.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_sel_encoder_rr_pick.sv | 40 ++++
 rtl/bus_sel_encoder.sv | 111 +++++++++++
 tb/tb_bus_sel_encoder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the common-bus source select logic.
//   SRC_N / SEL_W : number of select codes (code 0 reserved) and select width
//   SRC_*         : encoded source codes driven onto S2..S0
//   state_t       : arbitration FSM states
// -----------------------------------------------------------------------------
package bus_pkg;

   localparam int SRC_N = 8;
   localparam int SEL_W = 3;

   // Code 0 means nobody drives the bus; the remaining codes name the sources.
   localparam logic [SEL_W-1:0] SRC_NONE = 3'd0;
   localparam logic [SEL_W-1:0] SRC_AR   = 3'd1;
   localparam logic [SEL_W-1:0] SRC_PC   = 3'd2;
   localparam logic [SEL_W-1:0] SRC_DR   = 3'd3;
   localparam logic [SEL_W-1:0] SRC_AC   = 3'd4;
   localparam logic [SEL_W-1:0] SRC_IR   = 3'd5;
   localparam logic [SEL_W-1:0] SRC_TR   = 3'd6;
   localparam logic [SEL_W-1:0] SRC_MEM  = 3'd7;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage : bus_pkg

// File: rtl/bus_sel_encoder_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search over the effective request vector.
//   eff    : effective requests (bit 0 is never a real source)
//   rr_ptr : index of the most recent owner; search starts just above it
//   pick   : first requesting index found going upward with wrap
//   any    : at least one effective request is present
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int SRC_N = 8,
   parameter int SEL_W = 3
) (
   input  logic [SRC_N-1:0] eff,
   input  logic [SEL_W-1:0] rr_ptr,
   output logic [SEL_W-1:0] pick,
   output logic             any
);

   import bus_pkg::*;

   logic [SEL_W-1:0] idx;

   // Walk offsets 1..SRC_N from the pointer. SRC_N is a power of two, so the
   // wrap is just truncation of the sum; the final offset revisits rr_ptr
   // itself so a lone requester that is also the last owner is still found.
   // Index 0 is reserved and skipped even if a stray bit reaches it.
   always_comb begin
      pick = '0;
      any  = 1'b0;
      idx  = '0;
      for (int off = 1; off <= SRC_N; off++) begin
         idx = rr_ptr + SEL_W'(off);
         if (!any && (idx != '0) && eff[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule : rr_pick

// File: rtl/bus_sel_encoder.sv
// -----------------------------------------------------------------------------
// bus_sel_encoder
// Round-robin arbitrating encoder for the common-bus source select. Requests
// from the sources are arbitrated and the winner is presented as a registered
// 3-bit select plus the matching one-hot grant. The grant is held until the
// owner releases or drops its request; contention cycles are counted.
//   clk            : rising-edge clock
//   rst_n          : synchronous active-low reset
//   req            : per-source requests, bit 0 reserved and ignored
//   bus_release    : owner relinquishes the bus this cycle ("release" is a
//                    reserved word in SystemVerilog, hence the prefix)
//   sel            : encoded source select, 0 when idle
//   grant          : one-hot decode of sel, all-zero when idle
//   busy           : high while a source owns the bus
//   contention_cnt : saturating count of owned cycles with another requester
// -----------------------------------------------------------------------------
module bus_sel_encoder #(
   parameter int SRC_N = bus_pkg::SRC_N,
   parameter int SEL_W = bus_pkg::SEL_W,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SRC_N-1:0] req,
   input  logic             bus_release,
   output logic [SEL_W-1:0] sel,
   output logic [SRC_N-1:0] grant,
   output logic             busy,
   output logic [CNT_W-1:0] contention_cnt
);

   import bus_pkg::*;

   localparam logic [SRC_N-1:0] GRANT_LSB = SRC_N'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state;
   logic [SEL_W-1:0] rr_ptr;
   logic [SRC_N-1:0] eff;
   logic [SRC_N-1:0] others;
   logic [SEL_W-1:0] pick;
   logic             any;
   logic             end_cond;

   // Code 0 is "no source", so its request bit can never win arbitration.
   assign eff = {req[SRC_N-1:1], 1'b0};

   // Requesters other than the current owner; zero when idle apart from eff.
   assign others = eff & ~grant;

   // Ownership ends on an explicit release or when the owner drops its request.
   assign end_cond = bus_release | ~req[sel];

   rr_pick #(
      .SRC_N (SRC_N),
      .SEL_W (SEL_W)
   ) u_rr_pick (
      .eff    (eff),
      .rr_ptr (rr_ptr),
      .pick   (pick),
      .any    (any)
   );

   // Arbitration FSM with all outputs registered. On a handover the pointer
   // still holds the old owner, so the search naturally starts just past it
   // and the old owner can only win again if nobody else is waiting (which
   // cannot happen here because handover requires others != 0).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         rr_ptr         <= SEL_W'(SRC_N - 1);
         sel            <= '0;
         grant          <= '0;
         busy           <= 1'b0;
         contention_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any) begin
                  sel    <= pick;
                  grant  <= GRANT_LSB << pick;
                  busy   <= 1'b1;
                  rr_ptr <= pick;
                  state  <= GRANT;
               end
            end
            GRANT: begin
               if ((others != '0) && (contention_cnt != CNT_MAX)) begin
                  contention_cnt <= contention_cnt + CNT_W'(1);
               end
               if (end_cond) begin
                  if (others != '0) begin
                     sel    <= pick;
                     grant  <= GRANT_LSB << pick;
                     rr_ptr <= pick;
                  end else begin
                     sel   <= '0;
                     grant <= '0;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : bus_sel_encoder

// File: tb/tb_bus_sel_encoder.sv
// -----------------------------------------------------------------------------
// tb_bus_sel_encoder
// Directed stimulus for bus_sel_encoder. Each stimulus cycle queues the
// outputs expected after the next rising edge; an independent monitor pops
// and compares them, and also checks the grant/sel/busy invariants.
// -----------------------------------------------------------------------------
module tb_bus_sel_encoder;

   localparam int SRC_N = 8;
   localparam int SEL_W = 3;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [SRC_N-1:0] req = '0;
   logic             bus_release = 1'b0;
   logic [SEL_W-1:0] sel;
   logic [SRC_N-1:0] grant;
   logic             busy;
   logic [CNT_W-1:0] contention_cnt;

   typedef struct {
      string            name;
      logic [SEL_W-1:0] sel;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   bus_sel_encoder #(
      .SRC_N (SRC_N),
      .SEL_W (SEL_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req            (req),
      .bus_release    (bus_release),
      .sel            (sel),
      .grant          (grant),
      .busy           (busy),
      .contention_cnt (contention_cnt)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // One comparison: bumps the counters and reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs on the falling edge and queue what the outputs
   // must look like after the following rising edge.
   task automatic applyStimulus(input string name, input logic rst_v, input logic [SRC_N-1:0] req_v,
                                input logic rel_v, input logic [SEL_W-1:0] exp_sel,
                                input logic [CNT_W-1:0] exp_cnt);
      exp_t e;
      @(negedge clk);
      rst_n       = rst_v;
      req         = req_v;
      bus_release = rel_v;
      e.name = name;
      e.sel  = exp_sel;
      e.cnt  = exp_cnt;
      exp_q.push_back(e);
   endtask

   // Monitor: after every rising edge, pop one expectation if one is pending
   // and compare it, then check the structural invariants of the outputs.
   initial begin
      exp_t             e;
      logic [SRC_N-1:0] exp_grant;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_grant = (e.sel == '0) ? '0 : (SRC_N'(1) << e.sel);
            checkOutput({e.name, ".sel"},   32'(sel),            32'(e.sel));
            checkOutput({e.name, ".grant"}, 32'(grant),          32'(exp_grant));
            checkOutput({e.name, ".busy"},  32'(busy),           32'(e.sel != '0));
            checkOutput({e.name, ".cnt"},   32'(contention_cnt), 32'(e.cnt));
            checkOutput({e.name, ".onehot"}, 32'($countones(grant) <= 1), 32'(1));
            checkOutput({e.name, ".grant0"}, 32'(grant[0]), 32'(0));
            checkOutput({e.name, ".selbusy"}, 32'((sel == '0) == (busy == 1'b0)), 32'(1));
         end
      end
   end

   initial begin
      // Reset, then idle.
      applyStimulus("rst0",  1'b0, 8'b0000_0000, 1'b0, 3'd0, 8'd0);
      applyStimulus("rst1",  1'b0, 8'b0000_0000, 1'b0, 3'd0, 8'd0);
      applyStimulus("idle",  1'b1, 8'b0000_0000, 1'b0, 3'd0, 8'd0);

      // Single request: one cycle latency, then drop returns to idle.
      applyStimulus("single_req",  1'b1, 8'b0000_0100, 1'b0, 3'd2, 8'd0);
      applyStimulus("single_hold", 1'b1, 8'b0000_0100, 1'b0, 3'd2, 8'd0);
      applyStimulus("single_drop", 1'b1, 8'b0000_0000, 1'b0, 3'd0, 8'd0);
      applyStimulus("single_idle", 1'b1, 8'b0000_0000, 1'b0, 3'd0, 8'd0);

      // Reset puts the pointer back at 7 so the rotation starts at 1.
      applyStimulus("rr_rst", 1'b0, 8'b0000_0000, 1'b0, 3'd0, 8'd0);
      applyStimulus("rr_1",   1'b1, 8'b1001_0010, 1'b0, 3'd1, 8'd0);
      applyStimulus("rr_4",   1'b1, 8'b1001_0010, 1'b1, 3'd4, 8'd1);
      applyStimulus("rr_7",   1'b1, 8'b1001_0010, 1'b1, 3'd7, 8'd2);
      applyStimulus("rr_1b",  1'b1, 8'b1001_0010, 1'b1, 3'd1, 8'd3);
      applyStimulus("rr_4b",  1'b1, 8'b1001_0010, 1'b1, 3'd4, 8'd4);
      applyStimulus("rr_hold", 1'b1, 8'b1001_0010, 1'b0, 3'd4, 8'd5);
      applyStimulus("rr_end", 1'b1, 8'b0000_0000, 1'b0, 3'd0, 8'd5);

      // Reserved bit 0 never wins; with bit 1 also set, 1 wins (ptr=4).
      applyStimulus("res_only", 1'b1, 8'b0000_0001, 1'b0, 3'd0, 8'd5);
      applyStimulus("res_and1", 1'b1, 8'b0000_0011, 1'b0, 3'd1, 8'd5);
      applyStimulus("res_end",  1'b1, 8'b0000_0000, 1'b0, 3'd0, 8'd5);

      // Owner 3 holds while 6 waits; release hands over to 6.
      applyStimulus("hold_3",    1'b1, 8'b0000_1000, 1'b0, 3'd3, 8'd5);
      applyStimulus("hold_w1",   1'b1, 8'b0100_1000, 1'b0, 3'd3, 8'd6);
      applyStimulus("hold_w2",   1'b1, 8'b0100_1000, 1'b0, 3'd3, 8'd7);
      applyStimulus("hold_rel",  1'b1, 8'b0100_1000, 1'b1, 3'd6, 8'd8);
      applyStimulus("hold_6",    1'b1, 8'b0100_0000, 1'b0, 3'd6, 8'd8);
      applyStimulus("hold_end",  1'b1, 8'b0000_0000, 1'b0, 3'd0, 8'd8);

      // Release while idle has no effect.
      applyStimulus("idle_rel",  1'b1, 8'b0000_0000, 1'b1, 3'd0, 8'd8);

      // Grant 5 (pointer at 6, wraps past 7 and 0), then reset mid-grant.
      applyStimulus("mid_5",     1'b1, 8'b0010_0000, 1'b0, 3'd5, 8'd8);
      applyStimulus("mid_rst",   1'b0, 8'b0010_0000, 1'b0, 3'd0, 8'd0);

      // Saturation: owner 2 with 5 waiting for 300 cycles.
      applyStimulus("sat_start", 1'b1, 8'b0010_0100, 1'b0, 3'd2, 8'd0);
      for (int k = 1; k <= 300; k++) begin
         applyStimulus("sat", 1'b1, 8'b0010_0100, 1'b0, 3'd2, (k > 255) ? 8'd255 : 8'(k));
      end
      applyStimulus("sat_end",   1'b1, 8'b0000_0000, 1'b0, 3'd0, 8'd255);
      applyStimulus("sat_5",     1'b1, 8'b0010_0100, 1'b0, 3'd5, 8'd255);
      applyStimulus("sat_hand",  1'b1, 8'b0010_0100, 1'b1, 3'd2, 8'd255);
      applyStimulus("sat_drop",  1'b1, 8'b0000_0000, 1'b0, 3'd0, 8'd255);

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      checkOutput("drain", 32'(exp_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_bus_sel_encoder
